// File: rtl/program_loader.sv
// -----------------------------------------------------------------------------
// program_loader
//   Upstream feeder for the 8-bit CPU. Receives a framed program image
//   (SYNC, LEN, LEN payload bytes, CHK = 8-bit sum of payload) over a
//   valid/ready byte stream and writes the payload into the CPU's 256x8
//   memory. The CPU is held stalled until a frame loads with a good checksum.
//
// Ports
//   clk         in   system clock, rising edge
//   reset       in   asynchronous, active-low reset
//   start       in   1-cycle pulse: arm the loader for a new frame
//   in_data     in   [7:0] stream byte
//   in_valid    in   in_data valid
//   in_ready    out  loader can accept a byte (registered)
//   mem_we      out  memory write strobe, one pulse per payload byte
//   mem_addr    out  [7:0] memory write address
//   mem_wdata   out  [7:0] memory write data
//   cpu_hold    out  1 = CPU must stall; 0 only after a good load
//   load_done   out  last frame loaded with matching checksum
//   load_error  out  last frame failed (LEN=0, bad CHK, timeout)
//   byte_count  out  [7:0] payload bytes written in current/last frame
// -----------------------------------------------------------------------------
module program_loader #(
  parameter logic [7:0]  BASE_ADDR      = 8'h00,
  parameter logic [7:0]  SYNC_BYTE      = 8'hA5,
  parameter int unsigned TIMEOUT_CYCLES = 1024
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       start,
  input  logic [7:0] in_data,
  input  logic       in_valid,
  output logic       in_ready,
  output logic       mem_we,
  output logic [7:0] mem_addr,
  output logic [7:0] mem_wdata,
  output logic       cpu_hold,
  output logic       load_done,
  output logic       load_error,
  output logic [7:0] byte_count
);

  localparam int unsigned TW        = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [TW-1:0] TMO_LIMIT = TW'(TIMEOUT_CYCLES);
  localparam logic [TW-1:0] TMO_ONE   = {{(TW-1){1'b0}}, 1'b1};

  typedef enum logic [2:0] {
    ST_IDLE = 3'd0,
    ST_SYNC = 3'd1,
    ST_LEN  = 3'd2,
    ST_DATA = 3'd3,
    ST_CHK  = 3'd4,
    ST_DONE = 3'd5,
    ST_ERR  = 3'd6
  } state_e;

  // Running modulo-256 payload checksum.
  function automatic logic [7:0] sum8(input logic [7:0] acc, input logic [7:0] b);
    return acc + b;
  endfunction

  state_e        state_q, state_d;
  logic [7:0]    len_q, len_d;
  logic [7:0]    sum_q, sum_d;
  logic [TW-1:0] tmo_q, tmo_d;
  logic [7:0]    byte_count_q, byte_count_d;
  logic          mem_we_q, mem_we_d;
  logic [7:0]    mem_addr_q, mem_addr_d;
  logic [7:0]    mem_wdata_q, mem_wdata_d;
  logic          in_ready_q, in_ready_d;
  logic          cpu_hold_q, cpu_hold_d;
  logic          load_done_q, load_done_d;
  logic          load_error_q, load_error_d;

  logic          accept_s;
  logic          timeout_s;

  assign accept_s  = in_valid && in_ready_q;
  assign timeout_s = (tmo_q == TMO_LIMIT);

  // Next-state, datapath and next-output logic.
  always_comb begin
    state_d      = state_q;
    len_d        = len_q;
    sum_d        = sum_q;
    tmo_d        = tmo_q;
    byte_count_d = byte_count_q;
    mem_we_d     = 1'b0;
    mem_addr_d   = mem_addr_q;
    mem_wdata_d  = mem_wdata_q;

    case (state_q)
      ST_IDLE, ST_DONE, ST_ERR: begin
        if (start) begin
          state_d      = ST_SYNC;
          byte_count_d = 8'd0;
          sum_d        = 8'd0;
          tmo_d        = '0;
        end else begin
          state_d = state_q;
        end
      end

      ST_SYNC: begin
        // No timeout while hunting for SYNC; the counter is held clear so
        // LEN always starts from zero.
        tmo_d = '0;
        if (accept_s && (in_data == SYNC_BYTE)) begin
          state_d = ST_LEN;
        end else begin
          state_d = ST_SYNC;
        end
      end

      ST_LEN: begin
        if (accept_s) begin
          tmo_d = '0;
          if (in_data == 8'd0) begin
            state_d = ST_ERR;
          end else begin
            len_d   = in_data;
            state_d = ST_DATA;
          end
        end else if (timeout_s) begin
          state_d = ST_ERR;
        end else begin
          tmo_d = tmo_q + TMO_ONE;
        end
      end

      ST_DATA: begin
        if (accept_s) begin
          tmo_d        = '0;
          mem_we_d     = 1'b1;
          mem_addr_d   = BASE_ADDR + byte_count_q;
          mem_wdata_d  = in_data;
          byte_count_d = byte_count_q + 8'd1;
          sum_d        = sum8(sum_q, in_data);
          if ((byte_count_q + 8'd1) == len_q) begin
            state_d = ST_CHK;
          end else begin
            state_d = ST_DATA;
          end
        end else if (timeout_s) begin
          state_d = ST_ERR;
        end else begin
          tmo_d = tmo_q + TMO_ONE;
        end
      end

      ST_CHK: begin
        if (accept_s) begin
          tmo_d = '0;
          if (in_data == sum_q) begin
            state_d = ST_DONE;
          end else begin
            state_d = ST_ERR;
          end
        end else if (timeout_s) begin
          state_d = ST_ERR;
        end else begin
          tmo_d = tmo_q + TMO_ONE;
        end
      end

      default: begin
        state_d = ST_IDLE;
      end
    endcase

    // Status outputs are decoded from the next state so they register in
    // lockstep with it and have no combinational path to the inputs.
    in_ready_d   = (state_d == ST_SYNC) || (state_d == ST_LEN) ||
                   (state_d == ST_DATA) || (state_d == ST_CHK);
    cpu_hold_d   = (state_d != ST_DONE);
    load_done_d  = (state_d == ST_DONE);
    load_error_d = (state_d == ST_ERR);
  end

  // State, counters and registered outputs.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q      <= ST_IDLE;
      len_q        <= 8'd0;
      sum_q        <= 8'd0;
      tmo_q        <= '0;
      byte_count_q <= 8'd0;
      mem_we_q     <= 1'b0;
      mem_addr_q   <= 8'd0;
      mem_wdata_q  <= 8'd0;
      in_ready_q   <= 1'b0;
      cpu_hold_q   <= 1'b1;
      load_done_q  <= 1'b0;
      load_error_q <= 1'b0;
    end else begin
      state_q      <= state_d;
      len_q        <= len_d;
      sum_q        <= sum_d;
      tmo_q        <= tmo_d;
      byte_count_q <= byte_count_d;
      mem_we_q     <= mem_we_d;
      mem_addr_q   <= mem_addr_d;
      mem_wdata_q  <= mem_wdata_d;
      in_ready_q   <= in_ready_d;
      cpu_hold_q   <= cpu_hold_d;
      load_done_q  <= load_done_d;
      load_error_q <= load_error_d;
    end
  end

  assign in_ready   = in_ready_q;
  assign mem_we     = mem_we_q;
  assign mem_addr   = mem_addr_q;
  assign mem_wdata  = mem_wdata_q;
  assign cpu_hold   = cpu_hold_q;
  assign load_done  = load_done_q;
  assign load_error = load_error_q;
  assign byte_count = byte_count_q;

endmodule

// File: tb/tb_program_loader.sv
// -----------------------------------------------------------------------------
// tb_program_loader
//   Two loaders (BASE_ADDR 00 and F0, TIMEOUT_CYCLES 16) share one stream.
//   Expected writes and frame outcome are derived from the byte list of each
//   frame; writes are captured on the falling edge and compared afterwards.
// -----------------------------------------------------------------------------
module tb_program_loader;

  logic       clk = 1'b0;
  logic       rst_n, start, in_valid;
  logic [7:0] in_data;
  logic       in_ready0, mem_we0, cpu_hold0, load_done0, load_error0;
  logic [7:0] mem_addr0, mem_wdata0, byte_count0;
  logic       in_ready1, mem_we1, cpu_hold1, load_done1, load_error1;
  logic [7:0] mem_addr1, mem_wdata1, byte_count1;

  always #5 clk = ~clk;

  program_loader #(.BASE_ADDR(8'h00), .SYNC_BYTE(8'hA5), .TIMEOUT_CYCLES(16)) u_dut0 (
    .clk(clk), .reset(rst_n), .start(start), .in_data(in_data), .in_valid(in_valid),
    .in_ready(in_ready0), .mem_we(mem_we0), .mem_addr(mem_addr0), .mem_wdata(mem_wdata0),
    .cpu_hold(cpu_hold0), .load_done(load_done0), .load_error(load_error0),
    .byte_count(byte_count0));

  program_loader #(.BASE_ADDR(8'hF0), .SYNC_BYTE(8'hA5), .TIMEOUT_CYCLES(16)) u_dut1 (
    .clk(clk), .reset(rst_n), .start(start), .in_data(in_data), .in_valid(in_valid),
    .in_ready(in_ready1), .mem_we(mem_we1), .mem_addr(mem_addr1), .mem_wdata(mem_wdata1),
    .cpu_hold(cpu_hold1), .load_done(load_done1), .load_error(load_error1),
    .byte_count(byte_count1));

  typedef struct {
    logic [7:0] addr;
    logic [7:0] data;
    int         cyc;
  } wr_t;

  wr_t        wq0[$];
  wr_t        wq1[$];
  int         acc_q[$];
  logic [7:0] tx_q[$];
  int         cyc = 0;
  int         n_checks = 0;
  int         n_fail = 0;

  // model results for the frame in tx_q
  int         m_s, m_len, m_send, m_cnt;
  logic       m_ok;

  // Capture every write strobe with the cycle it was visible in.
  always @(negedge clk) begin
    if (mem_we0) wq0.push_back('{mem_addr0, mem_wdata0, cyc});
    if (mem_we1) wq1.push_back('{mem_addr1, mem_wdata1, cyc});
  end

  task automatic check_eq(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s actual=%0h expected=%0h (cycle %0d)", tag, act, exp, cyc);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
    cyc++;
  endtask

  task automatic check_reset_vals(input string tag);
    check_eq({tag, "_ready"}, {in_ready1, in_ready0}, 2'b00);
    check_eq({tag, "_we"},    {mem_we1, mem_we0}, 2'b00);
    check_eq({tag, "_addr"},  {mem_addr1, mem_addr0}, 16'h0000);
    check_eq({tag, "_wdata"}, {mem_wdata1, mem_wdata0}, 16'h0000);
    check_eq({tag, "_hold"},  {cpu_hold1, cpu_hold0}, 2'b11);
    check_eq({tag, "_done"},  {load_done1, load_done0}, 2'b00);
    check_eq({tag, "_err"},   {load_error1, load_error0}, 2'b00);
    check_eq({tag, "_count"}, {byte_count1, byte_count0}, 16'h0000);
  endtask

  // Frame outcome from the byte list alone.
  task automatic model_frame();
    int sum;
    m_s = 0;
    while (m_s < tx_q.size() && tx_q[m_s] != 8'hA5) m_s++;
    m_len = int'(tx_q[m_s + 1]);
    if (m_len == 0) begin
      m_send = m_s + 2;
      m_ok   = 1'b0;
      m_cnt  = 0;
    end else begin
      sum = 0;
      for (int k = 0; k < m_len; k++) sum += int'(tx_q[m_s + 2 + k]);
      m_ok   = (int'(tx_q[m_s + 2 + m_len]) == (sum % 256));
      m_send = m_s + 3 + m_len;
      m_cnt  = m_len;
    end
  endtask

  task automatic build_frame(input int garbage, input int len, input bit good);
    logic [7:0] b;
    int sum;
    tx_q.delete();
    for (int g = 0; g < garbage; g++) begin
      b = 8'($urandom_range(255, 0));
      if (b == 8'hA5) b = 8'h5A;
      tx_q.push_back(b);
    end
    tx_q.push_back(8'hA5);
    tx_q.push_back(8'(len));
    sum = 0;
    for (int k = 0; k < len; k++) begin
      b = 8'($urandom_range(255, 0));
      sum += int'(b);
      tx_q.push_back(b);
    end
    if (len != 0) begin
      b = 8'(sum % 256);
      if (!good) b = b ^ 8'($urandom_range(255, 1));
      tx_q.push_back(b);
    end
  endtask

  task automatic pulse_start(input string tag);
    in_valid = 1'b0;
    start    = 1'b1;
    tick();
    start    = 1'b0;
    wq0.delete();
    wq1.delete();
    acc_q.delete();
    check_eq({tag, "_arm_ready"}, {in_ready1, in_ready0}, 2'b11);
    check_eq({tag, "_arm_hold"},  {cpu_hold1, cpu_hold0}, 2'b11);
    check_eq({tag, "_arm_flags"}, {load_done1, load_error1, load_done0, load_error0}, 4'b0000);
    check_eq({tag, "_arm_count"}, {byte_count1, byte_count0}, 16'h0000);
  endtask

  // Present one byte after an idle gap; the loader must take it at once.
  task automatic send_byte(input logic [7:0] b, input int gap);
    in_valid = 1'b0;
    repeat (gap) tick();
    in_data  = b;
    in_valid = 1'b1;
    check_eq("byte_ready", {in_ready1, in_ready0}, 2'b11);
    acc_q.push_back(cyc + 1);
    tick();
    in_valid = 1'b0;
  endtask

  task automatic check_writes(input string tag, input int n, input int first_tx);
    check_eq({tag, "_nwr0"}, wq0.size(), n);
    check_eq({tag, "_nwr1"}, wq1.size(), n);
    for (int i = 0; i < n; i++) begin
      if (i < wq0.size() && i < wq1.size()) begin
        check_eq({tag, "_addr0"}, wq0[i].addr, 8'(i));
        check_eq({tag, "_addr1"}, wq1[i].addr, 8'(8'hF0 + i));
        check_eq({tag, "_data"},  {wq1[i].data, wq0[i].data},
                 {tx_q[first_tx + i], tx_q[first_tx + i]});
        check_eq({tag, "_wcyc"},  wq0[i].cyc, acc_q[first_tx + i]);
        check_eq({tag, "_wcyc1"}, wq1[i].cyc, acc_q[first_tx + i]);
      end
    end
  endtask

  task automatic run_frame(input string tag, input int gmin, input int gmax, input bit mid_start);
    pulse_start(tag);
    model_frame();
    for (int i = 0; i < m_send; i++) begin
      if (mid_start && i == m_s + 3) start = 1'b1;
      send_byte(tx_q[i], $urandom_range(gmax, gmin));
      start = 1'b0;
    end
    check_eq({tag, "_done"},  {load_done1, load_done0}, {m_ok, m_ok});
    check_eq({tag, "_err"},   {load_error1, load_error0}, {!m_ok, !m_ok});
    check_eq({tag, "_hold"},  {cpu_hold1, cpu_hold0}, {!m_ok, !m_ok});
    check_eq({tag, "_ready"}, {in_ready1, in_ready0}, 2'b00);
    check_eq({tag, "_count"}, {byte_count1, byte_count0}, {8'(m_cnt), 8'(m_cnt)});
    repeat (3) tick();
    check_eq({tag, "_hold_done"}, {load_done0, load_error0}, {m_ok, !m_ok});
    check_writes(tag, m_cnt, m_s + 2);
  endtask

  initial begin
    int n;
    rst_n    = 1'b1;
    start    = 1'b0;
    in_valid = 1'b0;
    in_data  = 8'h00;
    #1 rst_n = 1'b0;
    #1 check_reset_vals("rst");
    repeat (2) @(posedge clk);
    #3 rst_n = 1'b1;
    tick();
    check_reset_vals("idle");

    tx_q = '{8'hA5, 8'h03, 8'h10, 8'h20, 8'h30, 8'h60};
    run_frame("t1_good", 0, 0, 1'b0);

    tx_q = '{8'h00, 8'hFF, 8'hA5, 8'h01, 8'h7E, 8'h7E};
    run_frame("t2_skip", 0, 0, 1'b0);

    tx_q = '{8'hA5, 8'h03, 8'h10, 8'h20, 8'h30, 8'h61};
    run_frame("t3_badchk", 0, 0, 1'b0);

    tx_q = '{8'hA5, 8'h00};
    run_frame("t4_len0", 0, 0, 1'b0);

    // stall mid-DATA and let the idle timer expire
    tx_q = '{8'hA5, 8'h02, 8'h55};
    pulse_start("t5");
    for (int i = 0; i < 3; i++) send_byte(tx_q[i], 0);
    n = 0;
    while (!load_error0 && n < 64) begin
      tick();
      n++;
    end
    check_eq("t5_tmo_err",    {load_error1, load_error0}, 2'b11);
    check_eq("t5_tmo_window", (n >= 16 && n <= 18), 1'b1);
    check_eq("t5_tmo_hold",   {cpu_hold0, load_done0}, 2'b10);
    check_eq("t5_tmo_count",  byte_count0, 8'd1);
    check_writes("t5", 1, 2);
    build_frame(0, 4, 1'b1);
    run_frame("t5_recover", 0, 0, 1'b0);

    // wrapping frame with in_valid toggling every other cycle
    build_frame(0, 20, 1'b1);
    run_frame("t6_wrap", 1, 1, 1'b0);

    // reset mid-DATA
    build_frame(0, 20, 1'b1);
    pulse_start("t6r");
    for (int i = 0; i < 7; i++) send_byte(tx_q[i], 1);
    #2 rst_n = 1'b0;
    #1 check_reset_vals("t6_midrst");
    #10 rst_n = 1'b1;
    tick();
    check_reset_vals("t6_after");
    build_frame(2, 5, 1'b1);
    run_frame("t6_post", 0, 2, 1'b0);

    for (int f = 0; f < 25; f++) begin
      int mode, len;
      mode = $urandom_range(9, 0);
      len  = (mode == 0) ? 0 : (mode <= 2) ? 20 : $urandom_range(40, 1);
      build_frame($urandom_range(3, 0), len, ($urandom_range(3, 0) != 0));
      if (mode <= 2) run_frame("rnd", 1, 1, $urandom_range(1, 0));
      else           run_frame("rnd", 0, 3, $urandom_range(1, 0));
    end

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
